handshake_constant_seq: RTL
===========================

HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of outs.
REQ-002 SHALL have parameter VALUE, default 0, the constant emitted, truncated or zero-extended to DATA_WIDTH.
REQ-003 SHALL have parameter REPEAT, default 1, the number of output tokens per accepted ctrl token; legal range 1..65535.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low: sampled on the clk rising edge, asserted when 0.
REQ-006 SHALL have port ctrl_valid  input  1  control token offered.
REQ-007 SHALL have port ctrl_ready  output  1  control token accepted when ctrl_valid && ctrl_ready.
REQ-008 SHALL have port outs  output  DATA_WIDTH  constant data, always equal to VALUE.
REQ-009 SHALL have port outs_valid  output  1  output token offered; driven directly from a register.
REQ-010 SHALL have port outs_last  output  1  high with outs_valid on the final token of a burst.
REQ-011 SHALL have port outs_ready  input  1  output token consumed when outs_valid && outs_ready.

Function
REQ-012 SHALL implement FSM states IDLE (outs_valid=0) and EMIT (outs_valid=1), plus a remaining-count register cnt of width clog2(REPEAT+1).
REQ-013 In IDLE, ctrl_ready SHALL be 1; on ctrl_valid the next state SHALL be EMIT with cnt=REPEAT, so first outs_valid appears exactly 1 cycle after the ctrl handshake.
REQ-014 In EMIT, each output handshake SHALL decrement cnt by 1; without outs_ready, state, cnt and all outputs SHALL hold.
REQ-015 outs_last SHALL equal (state==EMIT && cnt==1).
REQ-016 In EMIT, ctrl_ready SHALL be (cnt==1 && outs_ready); otherwise 0.
REQ-017 On the final output handshake with ctrl_valid=1, the ctrl token SHALL be accepted in the same cycle, state SHALL stay EMIT, cnt SHALL reload to REPEAT, and outs_valid SHALL remain 1 with no bubble.
REQ-018 On the final output handshake with ctrl_valid=0, next state SHALL be IDLE.
REQ-019 Sustained throughput SHALL be one output token per cycle under continuous outs_ready; with REPEAT=1 the block SHALL accept one ctrl token per cycle.
REQ-020 outs_valid, once asserted, SHALL NOT deassert before its handshake completes (AXI-style stability).
REQ-021 The only combinational input-to-output path SHALL be outs_ready to ctrl_ready; ctrl_valid SHALL NOT combinationally affect any output.

Reset
REQ-022 While rst=0 at a clk edge, next state SHALL be IDLE, cnt=0, outs_valid=0, outs_last=0; ctrl_ready SHALL read 1 the cycle after.
REQ-023 Reset asserted mid-burst SHALL discard the remaining tokens; no token SHALL be emitted after the reset edge.
REQ-024 A ctrl handshake coinciding with the reset edge SHALL be dropped.

Configuration
REQ-025 Macro HANDSHAKE_CONSTANT_SEQ_IDX_EN, when defined, SHALL add port outs_idx  output  16  the zero-based index of the current token within its burst (REPEAT-cnt), reset to 0.
REQ-026 Without HANDSHAKE_CONSTANT_SEQ_IDX_EN, outs_idx SHALL be absent and all other behaviour identical.

Verification
REQ-027 REPEAT=3, VALUE=4, DATA_WIDTH=4, one ctrl pulse, outs_ready=1 -> outs_valid high cycles 1-3, outs=4'b0100, outs_last only cycle 3, then IDLE.
REQ-028 REPEAT=3, ctrl_valid held high, outs_ready=1 -> continuous outs_valid, outs_last every 3rd cycle, ctrl_ready pulses with each outs_last.
REQ-029 REPEAT=2, outs_ready low for 4 cycles mid-burst -> outs_valid, outs_last and cnt held, exactly 2 tokens delivered.
REQ-030 REPEAT=1, ctrl_valid=1 and outs_ready=1 for 10 cycles -> 10 output tokens in 10 cycles.
REQ-031 REPEAT=4, rst=0 after 2nd token -> outs_valid=0 next cycle, no further tokens, ctrl_ready=1.
REQ-032 With HANDSHAKE_CONSTANT_SEQ_IDX_EN, REPEAT=3 -> outs_idx sequence 0,1,2 per burst.

Source files
------------

// File: rtl/handshake_constant_seq.sv
// Purpose: on each accepted ctrl token, emit REPEAT copies of the constant VALUE on a valid/ready output.
// Latency: first outs_valid one cycle after the ctrl handshake; one token per cycle after that, no bubbles between bursts.
// Backpressure: outs_ready low freezes state, count and outputs; ctrl_ready is only offered when idle or on the final token.
// Optional: define HANDSHAKE_CONSTANT_SEQ_IDX_EN to add outs_idx (zero-based token index within the burst).
module handshake_constant_seq #(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned VALUE      = 0,
    parameter int          REPEAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    output logic                  outs_last,
    input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
    ,
    output logic [15:0]           outs_idx
`endif
);

    localparam int                     CNT_W     = $clog2(REPEAT + 1);
    localparam logic [CNT_W-1:0]       LP_REPEAT = CNT_W'(REPEAT);
    localparam logic [CNT_W-1:0]       LP_ONE    = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0]  LP_VALUE  = DATA_WIDTH'(VALUE);
    localparam logic                   LP_SINGLE = (REPEAT == 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_last;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_ctrl_ready;

`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
    logic [15:0]      r_idx;
`endif

    assign w_cnt_dec = r_cnt - LP_ONE;

    // r_last mirrors (EMIT && cnt==1), so the next ctrl token can only be taken when the last token leaves this cycle.
    assign w_ctrl_ready = (r_state == S_IDLE) || (r_last && outs_ready);

    // Burst FSM: state, remaining count and registered output flags move together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
            r_idx   <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ctrl_valid) begin
                        r_state <= S_EMIT;
                        r_cnt   <= LP_REPEAT;
                        r_valid <= 1'b1;
                        r_last  <= LP_SINGLE;
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
                        r_idx   <= 16'd0;
`endif
                    end
                end
                S_EMIT: begin
                    if (outs_ready) begin
                        if (r_last) begin
                            if (ctrl_valid) begin
                                // Back-to-back burst: reload without dropping outs_valid.
                                r_cnt   <= LP_REPEAT;
                                r_last  <= LP_SINGLE;
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
                                r_idx   <= 16'd0;
`endif
                            end else begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
                                r_idx   <= 16'd0;
`endif
                            end
                        end else begin
                            r_cnt  <= w_cnt_dec;
                            r_last <= (w_cnt_dec == LP_ONE);
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
                            r_idx  <= r_idx + 16'd1;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
                    r_idx   <= 16'd0;
`endif
                end
            endcase
        end
    end

    assign ctrl_ready = w_ctrl_ready;
    assign outs       = LP_VALUE;
    assign outs_valid = r_valid;
    assign outs_last  = r_last;
`ifdef HANDSHAKE_CONSTANT_SEQ_IDX_EN
    assign outs_idx   = r_idx;
`endif

endmodule
